// File: rtl/mul_result_buffer_pkg.sv
// Shared writeback types, the default multiplier-buffer depth and the branch squash predicate.
package mul_result_buffer_pkg;

    localparam int unsigned SQN_W        = 7;
    localparam int unsigned RESULT_W     = 32;
    localparam int unsigned FLAGS_W      = 4;
    localparam int unsigned MULBUF_DEPTH = 4;

    typedef logic [SQN_W-1:0] SqN;

    typedef struct packed {
        logic [RESULT_W-1:0] result;
        SqN                  sqN;
        logic [FLAGS_W-1:0]  flags;
        logic                valid;
    } RES_UOp;

    typedef struct packed {
        logic taken;
        SqN   sqN;
    } BranchProv;

    // Younger-than-branch test on a wrapping sequence number.
    function automatic logic is_killed(SqN x, BranchProv b);
        SqN diff;
        diff = x - b.sqN;
        return b.taken && !diff[SQN_W-1] && (diff != '0);
    endfunction

endpackage

// File: rtl/mul_result_buffer_res_fifo.sv
// DEPTH-entry result FIFO with per-entry valid bits that a taken branch clears in place.
module mul_result_buffer_res_fifo
    import mul_result_buffer_pkg::*;
#(
    parameter int unsigned  DEPTH = MULBUF_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  BranchProv        branch_i,
    input  logic             push_i,
    input  RES_UOp           push_uop_i,
    input  logic             pop_i,
    output RES_UOp           head_o,
    output logic             head_live_o,
    output logic             any_live_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o
);

    RES_UOp           entries_q [DEPTH];
    RES_UOp           entries_d [DEPTH];
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] live;
    logic             full;
    logic             do_pop;
    logic             do_push;

    // Kill evaluation looks only at pre-update contents.
    always_comb begin
        live = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i] = entries_q[i].valid && !is_killed(entries_q[i].sqN, branch_i);
        end
    end

    assign head_o       = entries_q[rptr_q];
    assign head_live_o  = live[rptr_q];
    assign any_live_o   = |live;
    assign full         = (count_q == CNT_W'(DEPTH));
    assign do_pop       = pop_i && (count_q != '0);
    assign do_push      = push_i && (!full || do_pop);
    assign count_o      = count_q;
    assign count_next_o = count_d;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i]       = entries_q[i];
            entries_d[i].valid = live[i];
        end
        if (do_pop) begin
            entries_d[rptr_q].valid = 1'b0;
        end
        // On a full push+pop wptr equals rptr, so the write must land last.
        if (do_push) begin
            entries_d[wptr_q] = push_uop_i;
        end
        rptr_d  = rptr_q + PTR_W'(do_pop);
        wptr_d  = wptr_q + PTR_W'(do_push);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_push: assert (!(push_i && full && !do_pop));
        end
    end

endmodule

// File: rtl/mul_result_buffer.sv
// Merges ALU and multiplier results onto one writeback port; ALU wins, mul results queue.
// Optional direct mul-to-writeback path enabled by defining MUL_RESBUF_BYPASS_EN.
module mul_result_buffer
    import mul_result_buffer_pkg::*;
#(
    parameter int unsigned  DEPTH = MULBUF_DEPTH,
    parameter int unsigned  SLACK = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  BranchProv        IN_branch,
    input  RES_UOp           IN_aluUop,
    input  RES_UOp           IN_mulUop,
    output RES_UOp           OUT_uop,
    output logic             OUT_mulStall,
    output logic [CNT_W-1:0] OUT_count
);

`ifdef MUL_RESBUF_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    RES_UOp           uop_q, uop_d;
    logic             stall_q, stall_d;
    RES_UOp           head;
    logic             head_live;
    logic             any_live;
    logic [CNT_W-1:0] count_next;
    logic             alu_live;
    logic             mul_live;
    logic             bypass;
    logic             push;
    logic             pop;

    assign alu_live = IN_aluUop.valid && !is_killed(IN_aluUop.sqN, IN_branch);
    assign mul_live = IN_mulUop.valid && !is_killed(IN_mulUop.sqN, IN_branch);
    assign bypass   = BYPASS_EN && !any_live && !alu_live && mul_live;
    assign push     = mul_live && !bypass;
    // A dead head drains even while the ALU owns the port.
    assign pop      = !(head_live && alu_live);

    always_comb begin
        uop_d = '0;
        if (alu_live) begin
            uop_d = IN_aluUop;
        end else if (head_live) begin
            uop_d = head;
        end else if (bypass) begin
            uop_d = IN_mulUop;
        end
        stall_d = (32'(count_next) + SLACK) >= DEPTH;
    end

    mul_result_buffer_res_fifo #(
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk          (clk),
        .rst          (rst),
        .branch_i     (IN_branch),
        .push_i       (push),
        .push_uop_i   (IN_mulUop),
        .pop_i        (pop),
        .head_o       (head),
        .head_live_o  (head_live),
        .any_live_o   (any_live),
        .count_o      (OUT_count),
        .count_next_o (count_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            uop_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            uop_q   <= uop_d;
            stall_q <= stall_d;
        end
    end

    assign OUT_uop      = uop_q;
    assign OUT_mulStall = stall_q;

endmodule

// File: tb/tb_mul_result_buffer.sv
// Table-driven and scoreboard bench for mul_result_buffer at DEPTH=4, SLACK=2.
module tb_mul_result_buffer;
    import mul_result_buffer_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    BranchProv br;
    RES_UOp    alu;
    RES_UOp    mul;
    RES_UOp    out;
    logic      stall;
    logic [2:0] count;

    always #5 clk = ~clk;

    mul_result_buffer #(
        .DEPTH (4),
        .SLACK (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_branch    (br),
        .IN_aluUop    (alu),
        .IN_mulUop    (mul),
        .OUT_uop      (out),
        .OUT_mulStall (stall),
        .OUT_count    (count)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic rst;
        logic alu_v;
        int   alu_sqn;
        logic mul_v;
        int   mul_sqn;
        logic br_t;
        int   br_sqn;
        logic exp_v;
        int   exp_sqn;
        int   exp_cnt;
        logic exp_stall;
    } row_t;

    row_t   rows[$];
    RES_UOp exp_q[$];

    function automatic RES_UOp mk(logic v, int s);
        RES_UOp u;
        u = '0;
        if (v) begin
            u.result = 32'hA500_0000 | 32'(s);
            u.sqN    = SqN'(s);
            u.flags  = 4'(s);
            u.valid  = 1'b1;
        end
        return u;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic av, input int as, input logic mv, input int ms,
                       input logic bt, input int bs, input logic ev, input int es, input int ec,
                       input logic est);
        row_t x;
        x = '{r, av, as, mv, ms, bt, bs, ev, es, ec, est};
        rows.push_back(x);
    endtask

    task automatic apply_row(input row_t x, input int idx);
        RES_UOp e;
        rst = x.rst;
        alu = mk(x.alu_v, x.alu_sqn);
        mul = mk(x.mul_v, x.mul_sqn);
        br  = '{taken: x.br_t, sqN: SqN'(x.br_sqn)};
        @(posedge clk);
        #1;
        e = mk(1'b1, x.exp_sqn);
        check($sformatf("row%0d valid", idx), int'(out.valid), int'(x.exp_v));
        if (x.exp_v) begin
            check($sformatf("row%0d sqN", idx), int'(out.sqN), x.exp_sqn);
            check($sformatf("row%0d result", idx), int'(out.result), int'(e.result));
            check($sformatf("row%0d flags", idx), int'(out.flags), int'(e.flags));
        end
        check($sformatf("row%0d count", idx), int'(count), x.exp_cnt);
        check($sformatf("row%0d stall", idx), int'(stall), int'(x.exp_stall));
    endtask

    task automatic sb_check();
        RES_UOp e;
        check("wrap count<=1", int'(count <= 3'd1), 1);
        if (out.valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb unexpected: got sqN %0d, expected no output", out.sqN);
            end else begin
                e = exp_q.pop_front();
                check("sb sqN", int'(out.sqN), int'(e.sqN));
                check("sb result", int'(out.result), int'(e.result));
            end
        end
    endtask

    initial begin
        // rst alu_v alu_sqn mul_v mul_sqn br_t br_sqn | exp_v exp_sqn cnt stall
        // Reset with 3 queued entries
        add(0, 1, 50, 1, 60, 0, 0,   1, 50, 1, 0);
        add(0, 1, 51, 1, 61, 0, 0,   1, 51, 2, 1);
        add(0, 1, 52, 1, 62, 0, 0,   1, 52, 3, 1);
        add(1, 0, 0,  0, 0,  0, 0,   0, 0,  0, 0);
        add(1, 0, 0,  0, 0,  0, 0,   0, 0,  0, 0);
        add(0, 0, 0,  0, 0,  0, 0,   0, 0,  0, 0);
        add(0, 0, 0,  0, 0,  0, 0,   0, 0,  0, 0);
        // ALU/mul conflict
        add(0, 1, 10, 1, 9,  0, 0,   1, 10, 1, 0);
        add(0, 0, 0,  0, 0,  0, 0,   1, 9,  0, 0);
        add(0, 0, 0,  0, 0,  0, 0,   0, 0,  0, 0);
        // Fill to DEPTH under a busy ALU, then drain
        add(0, 1, 20, 1, 30, 0, 0,   1, 20, 1, 0);
        add(0, 1, 21, 1, 31, 0, 0,   1, 21, 2, 1);
        add(0, 1, 22, 1, 32, 0, 0,   1, 22, 3, 1);
        add(0, 1, 23, 1, 33, 0, 0,   1, 23, 4, 1);
        add(0, 0, 0,  0, 0,  0, 0,   1, 30, 3, 1);
        add(0, 0, 0,  0, 0,  0, 0,   1, 31, 2, 1);
        add(0, 0, 0,  0, 0,  0, 0,   1, 32, 1, 0);
        add(0, 0, 0,  0, 0,  0, 0,   1, 33, 0, 0);
        add(0, 0, 0,  0, 0,  0, 0,   0, 0,  0, 0);
        // Flush: queue 5,7,9 then branch at 6
        add(0, 1, 1,  1, 5,  0, 0,   1, 1,  1, 0);
        add(0, 1, 2,  1, 7,  0, 0,   1, 2,  2, 1);
        add(0, 1, 3,  1, 9,  0, 0,   1, 3,  3, 1);
        add(0, 0, 0,  0, 0,  1, 6,   1, 5,  2, 1);
        add(0, 0, 0,  0, 0,  0, 0,   0, 0,  1, 0);
        add(0, 0, 0,  0, 0,  0, 0,   0, 0,  0, 0);
        // Squash of incoming uops, equal sqN, and sqN wrap
        add(0, 1, 41, 1, 42, 1, 40,  0, 0,  0, 0);
        add(0, 1, 40, 0, 0,  1, 40,  1, 40, 0, 0);
        add(0, 1, 2,  0, 0,  1, 120, 0, 0,  0, 0);
        add(0, 1, 119, 0, 0, 1, 120, 1, 119, 0, 0);

        rst = 1'b1;
        alu = '0;
        mul = '0;
        br  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid", int'(out.valid), 0);
        check("reset count", int'(count), 0);
        check("reset stall", int'(stall), 0);

        for (int i = 0; i < rows.size(); i++) begin
            apply_row(rows[i], i);
        end

        // Pointer wrap with one push per cycle, scoreboarded
        rst = 1'b0;
        alu = '0;
        br  = '0;
        for (int i = 0; i < 10; i++) begin
            mul = mk(1'b1, 64 + i);
            mul.result = $urandom;
            exp_q.push_back(mul);
            @(posedge clk);
            #1;
            sb_check();
        end
        mul = '0;
        for (int c = 0; c < 8 && exp_q.size() > 0; c++) begin
            @(posedge clk);
            #1;
            sb_check();
        end
        check("wrap drained", exp_q.size(), 0);
        check("wrap final count", int'(count), 0);

        // Mul into an empty FIFO with the ALU idle
        mul = mk(1'b1, 3);
        @(posedge clk);
        #1;
        mul = '0;
`ifdef MUL_RESBUF_BYPASS_EN
        check("bypass valid", int'(out.valid), 1);
        check("bypass sqN", int'(out.sqN), 3);
        check("bypass count", int'(count), 0);
`else
        check("nobypass valid t1", int'(out.valid), 0);
        check("nobypass count t1", int'(count), 1);
        @(posedge clk);
        #1;
        check("nobypass valid t2", int'(out.valid), 1);
        check("nobypass sqN t2", int'(out.sqN), 3);
        check("nobypass count t2", int'(count), 0);
`endif
        @(posedge clk);
        #1;
        check("idle after mul", int'(out.valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
